// File: rtl/pbit_synapse.sv
// Serial multiply-accumulate synapse: turns neighbour p-bit states, stored couplings
// J[j] and local field h into a saturated bias z plus an enable pulse for one p-bit.
module pbit_synapse #(
  parameter int N         = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16,
  parameter int Z_WIDTH   = 7
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [N-1:0]               m_vec,
  input  logic                       wr_en,
  input  logic [$clog2(N+1)-1:0]     wr_addr,
  input  logic [W_WIDTH-1:0]         wr_data,
  output logic [Z_WIDTH-1:0]         z,
  output logic                       z_valid,
  output logic                       pbit_en,
  output logic                       busy,
  output logic                       wr_drop
);

  localparam int ADDR_W = $clog2(N + 1);
  localparam int IDX_W  = $clog2(N);
  localparam logic [ADDR_W-1:0] H_ADDR   = ADDR_W'(N);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [ACC_WIDTH-1:0] Z_MAX = ACC_WIDTH'((2 ** (Z_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Z_MIN = ACC_WIDTH'(-(2 ** (Z_WIDTH - 1)));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SAT   = 2'd2
  } state_t;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [W_WIDTH-1:0] v);
    return {{(ACC_WIDTH - W_WIDTH){v[W_WIDTH-1]}}, v};
  endfunction

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [N-1:0]                 snap_q, snap_d;
  logic [W_WIDTH-1:0]           j_q [N];
  logic [W_WIDTH-1:0]           j_d [N];
  logic [W_WIDTH-1:0]           h_q, h_d;
  logic                         pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]             pend_addr_q, pend_addr_d;
  logic [W_WIDTH-1:0]           pend_data_q, pend_data_d;
  logic [Z_WIDTH-1:0]           z_q, z_d;
  logic                         z_valid_q, z_valid_d;
  logic                         busy_q, busy_d;
  logic                         wr_drop_q, wr_drop_d;
  logic signed [ACC_WIDTH-1:0]  term_s;

  // Next-state, datapath and write-port decode.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    j_d         = j_q;
    h_d         = h_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    z_d         = z_q;
    z_valid_d   = 1'b0;
    wr_drop_d   = 1'b0;
    term_s      = sext(j_q[idx_q]);

    // A weight write landing with start is parked until the run ends so the run sees the old J.
    if (wr_en) begin
      if ((state_q != S_IDLE) || (wr_addr > H_ADDR)) begin
        wr_drop_d = 1'b1;
      end else if (wr_addr == H_ADDR) begin
        h_d = wr_data;
      end else if (start) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = wr_addr[IDX_W-1:0];
        pend_data_d = wr_data;
      end else begin
        j_d[wr_addr[IDX_W-1:0]] = wr_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = m_vec;
          acc_d   = sext(h_q);
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (snap_q[idx_q]) begin
          acc_d = acc_q + term_s;
        end else begin
          acc_d = acc_q - term_s;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_SAT;
        end
      end
      S_SAT: begin
        if (acc_q > Z_MAX) begin
          z_d = Z_MAX[Z_WIDTH-1:0];
        end else if (acc_q < Z_MIN) begin
          z_d = Z_MIN[Z_WIDTH-1:0];
        end else begin
          z_d = acc_q[Z_WIDTH-1:0];
        end
        z_valid_d = 1'b1;
        state_d   = S_IDLE;
        if (pend_vld_q) begin
          j_d[pend_addr_q] = pend_data_q;
          pend_vld_d       = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and storage registers; reset aborts any run in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      snap_q      <= '0;
      j_q         <= '{default: '0};
      h_q         <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      z_q         <= '0;
      z_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      j_q         <= j_d;
      h_q         <= h_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      z_q         <= z_d;
      z_valid_q   <= z_valid_d;
      busy_q      <= busy_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign pbit_en = z_valid_q;
  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_pbit_synapse.sv
// Directed plus randomized bench for pbit_synapse; expectations come from a
// plain-integer model of the weighted sum and its saturation.
module tb_pbit_synapse;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] m_vec;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] z;
  logic       z_valid, pbit_en, busy, wr_drop;

  int checks   = 0;
  int failures = 0;
  int jm [8];
  int hm;

  pbit_synapse dut (
    .CLK(CLK), .RST(RST), .start(start), .m_vec(m_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .z(z), .z_valid(z_valid), .pbit_en(pbit_en), .busy(busy), .wr_drop(wr_drop)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_z(input logic [7:0] mv);
    int s;
    logic [31:0] t;
    s = hm;
    for (int j = 0; j < 8; j++) s += mv[j] ? jm[j] : -jm[j];
    if (s > 63) s = 63;
    else if (s < -64) s = -64;
    t = s;
    return t[6:0];
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    logic signed [7:0] ds;
    ds = d;
    if (a < 4'd8) jm[a] = ds;
    else hm = ds;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic exp_drop);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    chk("wr_drop", {31'd0, wr_drop}, {31'd0, exp_drop});
    if (!exp_drop) model_write(a, d);
  endtask

  task automatic set_all(input logic [7:0] jv, input logic [7:0] hv);
    for (int j = 0; j < 8; j++) wr(j[3:0], jv, 1'b0);
    wr(4'd8, hv, 1'b0);
  endtask

  // mode: 0 plain, 1 flip m_vec and re-start mid-run, 2 write J[0] mid-run,
  // 3 write h with start, 4 write J[1] with start
  task automatic run(input logic [7:0] mv, input int mode, input string tag);
    int n, busy_cnt, extra;
    logic done;
    logic [6:0] exp_z;
    exp_z = model_z(mv);
    m_vec = mv; start = 1'b1;
    if (mode == 3) begin wr_en = 1'b1; wr_addr = 4'd8; wr_data = 8'd7; end
    if (mode == 4) begin wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h21; end
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (mode == 3 || mode == 4) begin
      chk({tag, "_same_cycle_wr_drop"}, {31'd0, wr_drop}, 32'd0);
      model_write(wr_addr, wr_data);
    end
    busy_cnt = busy;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      if (mode == 1 && n == 3) begin m_vec = ~mv; start = 1'b1; end
      if (mode == 1 && n == 4) start = 1'b0;
      if (mode == 2 && n == 2) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h55; end
      if (mode == 2 && n == 3) wr_en = 1'b0;
      tick();
      n++;
      if (mode == 2 && n == 3) chk({tag, "_busy_wr_drop"}, {31'd0, wr_drop}, 32'd1);
      busy_cnt += busy;
      if (z_valid) done = 1'b1;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_latency"}, n, 32'd9);
    chk({tag, "_busy_cycles"}, busy_cnt, 32'd9);
    chk({tag, "_z"}, {25'd0, z}, {25'd0, exp_z});
    chk({tag, "_pbit_en"}, {31'd0, pbit_en}, 32'd1);
    tick();
    chk({tag, "_zv_pulse"}, {31'd0, z_valid}, 32'd0);
    chk({tag, "_z_hold"}, {25'd0, z}, {25'd0, exp_z});
    if (mode == 1) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin tick(); extra += z_valid; end
      chk({tag, "_extra_zv"}, extra, 32'd0);
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] d;
    RST = 1'b0; start = 1'b0; m_vec = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int j = 0; j < 8; j++) jm[j] = 0;
    hm = 0;
    tick(); tick();
    chk("rst_z", {25'd0, z}, 32'd0);
    chk("rst_zv", {30'd0, z_valid, pbit_en}, 32'd0);
    chk("rst_busy_drop", {30'd0, busy, wr_drop}, 32'd0);
    RST = 1'b1;
    tick();

    run(8'hA5, 0, "zero");

    set_all(8'd5, 8'd3);
    run(8'h0F, 0, "balanced");

    set_all(8'd10, 8'd0);
    run(8'hFF, 0, "sat_pos");
    run(8'h00, 0, "sat_neg");
    set_all(8'h80, 8'h80);
    run(8'hFF, 0, "min_w_neg");
    run(8'h00, 0, "min_w_pos");

    for (int j = 0; j < 8; j++) wr(j[3:0], 8'(j - 3), 1'b0);
    wr(4'd8, 8'd2, 1'b0);
    run(8'hFF, 1, "snapshot");
    run(8'h3C, 2, "busy_write");
    run(8'h3C, 0, "after_busy_write");
    wr(4'd9, 8'h7F, 1'b1);
    wr(4'd15, 8'h80, 1'b1);
    run(8'h96, 0, "after_bad_addr");
    run(8'h96, 3, "h_same_cycle");
    run(8'h96, 0, "h_new");
    run(8'h5A, 4, "j_same_cycle");
    run(8'h5A, 0, "j_new");

    for (int it = 0; it < 10; it++) begin
      for (int j = 0; j < 9; j++) begin
        d = (it % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'(int'($urandom_range(0, 20)) - 10);
        wr(j[3:0], d, 1'b0);
      end
      run(8'($urandom), 0, "random");
    end

    set_all(8'd10, 8'd0);
    run(8'hFF, 0, "pre_reset");
    m_vec = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    RST = 1'b0;
    #1;
    chk("mid_rst_z", {25'd0, z}, 32'd0);
    chk("mid_rst_zv", {30'd0, z_valid, pbit_en}, 32'd0);
    chk("mid_rst_busy_drop", {30'd0, busy, wr_drop}, 32'd0);
    tick();
    RST = 1'b1;
    for (int j = 0; j < 8; j++) jm[j] = 0;
    hm = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin tick(); cnt += z_valid; end
    chk("post_rst_no_zv", cnt, 32'd0);
    chk("post_rst_z", {25'd0, z}, 32'd0);
    run(8'hC3, 0, "post_rst_weights");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
